// File: rtl/elevator_scheduler_pkg.sv
// elevator_scheduler_pkg: shared floor sizing, FSM state codes and counter direction encoding
package elevator_scheduler_pkg;
  localparam int FLOOR_W = 4;
  localparam int N_FLOORS = 1 << FLOOR_W;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MOVE = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] DOOR = 2'd3;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/elevator_scheduler_dwell_timer.sv
// elevator_scheduler_dwell_timer: loadable down-counter whose terminal-count flag marks the last cycle of a dwell
module elevator_scheduler_dwell_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge clear)
    if (!clear) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - W'(1);
  assign tc = cnt == '0;
endmodule

// File: rtl/elevator_scheduler.sv
// elevator_scheduler: collective (SCAN) call scheduler driving the floor counter's step enable and direction
module elevator_scheduler #(
  parameter int N_FLOORS = elevator_scheduler_pkg::N_FLOORS,
  parameter int FLOOR_W = elevator_scheduler_pkg::FLOOR_W,
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 8
) (
  input  logic                clk,
  input  logic                clear,
  input  logic [N_FLOORS-1:0] call_req,
  input  logic [FLOOR_W-1:0]  floor,
  output logic                step,
  output logic                dir,
  output logic                door_open,
  output logic                moving,
  output logic [N_FLOORS-1:0] pending
);
  import elevator_scheduler_pkg::*;
  localparam int MW = $clog2(MOVE_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  logic [1:0] state, state_n;
  logic dir_n, here, above, below, fwd, rev, edge_bad, absorb, move_tc, door_tc;
  logic [N_FLOORS-1:0] fbit, lo_mask, clr, set;
  assign fbit = N_FLOORS'(1) << floor;
  assign lo_mask = fbit - N_FLOORS'(1);
  assign here = |(pending & fbit);
  assign below = |(pending & lo_mask);
  assign above = |(pending & ~lo_mask & ~fbit);
  assign fwd = dir ? below : above;
  assign rev = dir ? above : below;
  assign edge_bad = dir ? ~|floor : &floor;
  assign absorb = state == DOOR && call_req[floor];
  assign set = state == DOOR ? call_req & ~fbit : call_req;
  assign clr = (state == IDLE || state == CHECK) && here ? fbit : '0;
  assign step = state == MOVE && move_tc && !edge_bad;
  assign door_open = state == DOOR;
  assign moving = state == MOVE || state == CHECK;
  always_comb begin
    state_n = state;
    dir_n = dir;
    unique case (state)
      IDLE, CHECK: begin
        state_n = here ? DOOR : (fwd || rev) ? MOVE : IDLE;
        dir_n = !here && !fwd && rev ? ~dir : dir;
      end
      MOVE: state_n = !move_tc ? MOVE : edge_bad ? IDLE : CHECK;
      DOOR: state_n = door_tc && !absorb ? IDLE : DOOR;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge clear)
    if (!clear) begin
      state <= IDLE;
      dir <= DIR_UP;
      pending <= '0;
    end else begin
      state <= state_n;
      dir <= dir_n;
      pending <= (pending & ~clr) | set;
    end
  elevator_scheduler_dwell_timer #(.W(MW)) u_move (
    .clk(clk), .clear(clear), .load(state != MOVE),
    .load_val(MW'(MOVE_CYCLES - 1)), .tc(move_tc)
  );
  elevator_scheduler_dwell_timer #(.W(DW)) u_door (
    .clk(clk), .clear(clear), .load(state != DOOR || absorb),
    .load_val(DW'(DOOR_CYCLES - 1)), .tc(door_tc)
  );
endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
- Controller that sequences the 4-bit up/down floor counter. Collects floor calls, picks the travel direction, and issues one-cycle step enables. Runs the door-open dwell at each served floor.
- Sits between the call buttons and the floor counter. Drives the counter's enable (habilitar) and direction (C) inputs, and reads back its S output as the current floor.

Parameters:
- N_FLOORS, 16, number of floors; must equal 2**FLOOR_W.
- FLOOR_W, 4, floor index width; matches the counter output width.
- MOVE_CYCLES, 4, clocks of travel per floor; the step pulse fires on the last of them; must be >= 1.
- DOOR_CYCLES, 8, clocks door_open stays high per stop; must be >= 1.

Ports:
- clk  in  1  system clock, shared with the floor counter.
- clear  in  1  asynchronous, active-low reset; also drives the floor counter's clear.
- call_req  in  N_FLOORS  one-hot or multi-hot call pulses, one bit per floor.
- floor  in  FLOOR_W  current floor from the counter's S output.
- step  out  1  one-cycle enable to the counter's habilitar input.
- dir  out  1  counter direction: 0 = up, 1 = down; same encoding as the counter's C input.
- door_open  out  1  high while the door dwell runs.
- moving  out  1  high in the MOVE and CHECK states.
- pending  out  N_FLOORS  registered outstanding-call mask.

Behaviour:
- Reset (clear=0, asynchronous):
  - State goes to IDLE.
  - pending=0, step=0, dir=0, door_open=0, moving=0.
  - Timers go to 0.
- Call capture:
  - pending |= call_req at every clock edge, so a call is visible on pending one cycle after it is asserted.
  - A call for the floor currently in DOOR is absorbed (not latched) and restarts the door timer.
- Definitions:
  - above = OR of pending bits with index > floor.
  - below = OR of pending bits with index < floor.
  - here = pending[floor].
- IDLE:
  - If here: clear that bit and go to DOOR.
  - Else if above or below: go to MOVE. dir keeps its value if requests remain in that direction; otherwise dir toggles. Up wins when dir=0, down wins when dir=1.
  - Else stay in IDLE.
- MOVE:
  - Timer counts 0..MOVE_CYCLES-1.
  - At the terminal count, step=1 for exactly that cycle and the state goes to CHECK.
  - The counter updates floor on that same edge.
- CHECK (one cycle, reads the updated floor):
  - If here: clear that bit and go to DOOR.
  - Else if requests remain in dir: go to MOVE.
  - Else if requests remain opposite: toggle dir and go to MOVE.
  - Else go to IDLE.
- DOOR:
  - door_open=1 for DOOR_CYCLES cycles, then go to IDLE.
  - IDLE re-evaluates direction, so collective (SCAN) service is kept.
- dir changes only in IDLE or CHECK, never in a cycle where step=1.
- Wrap guard:
  - step is never asserted with dir=0 at floor=N_FLOORS-1, nor with dir=1 at floor=0.
  - If the guard would be violated, the block goes to IDLE instead.
- Simultaneous set and clear of the same pending bit: the set wins, except for the floor being served in DOOR (absorbed).
- Reset mid-move aborts immediately. No step pulse is emitted after clear falls.

Decomposition:
- Shared package holds:
  - state encoding: IDLE, MOVE, CHECK, DOOR.
  - direction constants DIR_UP=0 and DIR_DOWN=1, shared with the floor counter's C input.
  - FLOOR_W and N_FLOORS.
- One natural sub-module: dwell_timer, a loadable down-counter with a terminal-count flag. It is instantiated twice, for the move timer and the door timer.

Test Plan:
- Reset, floor=0, call_req[5] pulse:
  - pending=0x0020 the next cycle.
  - Five step pulses, each MOVE_CYCLES apart, with dir=0 throughout.
  - door_open high for 8 cycles once floor=5.
  - pending=0 at the end.
- At floor 5 moving up, calls at 9 and 2:
  - Stops at 9 first, then dir=1 and service of 2.
  - Exactly 7 down steps; no step pulse coincides with a dir change.
- Call for the current floor while in DOOR:
  - Door timer restarts; door_open stays high for 8 more cycles.
  - The pending bit for that floor stays 0.
- Call at floor 15 while idle at 15: go to DOOR with no step pulse. Call at floor 0 from 15: 15 down steps, and floor never wraps past 0.
- clear asserted during the third cycle of MOVE:
  - All outputs 0 immediately (asynchronous).
  - No step pulse afterwards; the block resumes from IDLE after clear rises.
- call_req bits set in the same cycle as the CHECK-state clear of that floor: the bit stays set and is served again by the next DOOR.
